// File: rtl/rr_mux.sv
// -----------------------------------------------------------------------------
// rr_mux -- registered M-channel round-robin multiplexer with valid/ready
// handshakes on every input and on the output.
//
// Several producers share one downstream consumer. This block replaces the
// older combinational 4:1 select mux. A rotating priority pointer chooses the
// input, so there is no external select. One output register gives a
// one-cycle latency and full throughput, including drain and refill in the
// same cycle.
//
// Parameters:
//   N   data width per channel (>= 1)
//   M   number of input channels (>= 2, need not be a power of two)
//   SW  channel index width, derived as $clog2(M)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous, active-low reset
//   in_data    packed input words; channel i occupies [i*N +: N]
//   in_valid   per-channel valid
//   in_ready   per-channel ready; one-hot or zero
//   out_data   registered output word
//   out_chan   channel index that produced out_data
//   out_valid  output register holds a word
//   out_ready  downstream accepts the word
//
// Optional feature (macro RR_MUX_FORCE_EN):
//   force_en   when high, only channel force_sel is eligible
//   force_sel  forced channel index; values >= M grant nothing
// -----------------------------------------------------------------------------
module rr_mux #(
    parameter int N = 8,
    parameter int M = 4,
    localparam int SW = $clog2(M)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [M*N-1:0] in_data,
    input  logic [M-1:0]   in_valid,
    output logic [M-1:0]   in_ready,
    output logic [N-1:0]   out_data,
    output logic [SW-1:0]  out_chan,
    output logic           out_valid,
    input  logic           out_ready
`ifdef RR_MUX_FORCE_EN
    ,
    input  logic           force_en,
    input  logic [SW-1:0]  force_sel
`endif
);

    // M expressed one bit wider than a channel index. The wrap arithmetic
    // (ptr + k, with k up to M) fits without overflow at this width.
    localparam logic [SW:0]   M_W     = (SW+1)'(M);
    localparam logic [SW-1:0] PTR_RST = SW'(M - 1);

    // Registered state
    logic [N-1:0]  out_data_q,  out_data_d;
    logic [SW-1:0] out_chan_q,  out_chan_d;
    logic          out_valid_q, out_valid_d;
    logic [SW-1:0] ptr_q,       ptr_d;

    // Combinational helpers
    logic [N-1:0]  in_word [M];
    logic [M-1:0]  eligible;
    logic [SW:0]   cand;
    logic          grant_found;
    logic [SW-1:0] grant_idx;
    logic          load;
    logic          transfer;

    // Unpack the flat input bus into one word per channel.
    generate
        for (genvar gi = 0; gi < M; gi++) begin : g_unpack
            assign in_word[gi] = in_data[gi*N +: N];
        end
    endgenerate

    // Eligible set: every valid channel. With forcing enabled, only the
    // selected channel is eligible. An out-of-range select leaves the set empty.
`ifdef RR_MUX_FORCE_EN
    always_comb begin
        eligible = '0;
        if (!force_en) begin
            eligible = in_valid;
        end else if ({1'b0, force_sel} < M_W) begin
            eligible[force_sel] = in_valid[force_sel];
        end
    end
`else
    always_comb begin
        eligible = in_valid;
    end
`endif

    // Rotating-priority search. Candidates are visited in the order ptr+1,
    // ptr+2, ..., ptr (mod M). The first eligible candidate wins. ptr_q is
    // always < M, so a single conditional subtract wraps each candidate.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= M; k++) begin
            cand = {1'b0, ptr_q} + (SW+1)'(k);
            if (cand >= M_W) begin
                cand = cand - M_W;
            end
            if (!grant_found && eligible[cand[SW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[SW-1:0];
            end
        end
    end

    // The register can take a word when it is empty or is being drained.
    assign load     = ~out_valid_q | out_ready;
    assign transfer = load & grant_found;

    // Ready goes only to the granted channel. It is held low during reset so
    // that no producer sees a handshake which the reset would discard.
    generate
        for (genvar gi = 0; gi < M; gi++) begin : g_ready
            assign in_ready[gi] = rst_n & transfer & (grant_idx == SW'(gi));
        end
    endgenerate

    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (transfer) begin
            out_data_d  = in_word[grant_idx];
            out_chan_d  = grant_idx;
            out_valid_d = 1'b1;
            ptr_d       = grant_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // After reset, ptr points at the last channel, so channel 0 is searched first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= PTR_RST;
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_mux.sv
// -----------------------------------------------------------------------------
// tb_rr_mux -- self-checking bench for rr_mux.
//
// Runs two instances side by side: M=4 (power of two) and M=3 (wrap case).
// A reference model drives the expected values. The model keeps a priority
// pointer, a full flag and the held word per instance, and picks grants
// with modulo arithmetic. Directed steps add checks against constant
// expected values. A random phase follows that respects the
// hold-until-accepted input rule.
// -----------------------------------------------------------------------------
module tb_rr_mux;

    logic        clk = 1'b0;
    logic        rst_n;

    // M=4 instance
    logic [3:0]  v4;
    logic [31:0] d4;
    logic        r4;
    logic [3:0]  rdy4;
    logic [7:0]  od4;
    logic [1:0]  oc4;
    logic        ov4;
    logic        fe4;
    logic [1:0]  fs4;

    // M=3 instance
    logic [2:0]  v3;
    logic [23:0] d3;
    logic        r3;
    logic [2:0]  rdy3;
    logic [7:0]  od3;
    logic [1:0]  oc3;
    logic        ov3;
    logic        fe3;
    logic [1:0]  fs3;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state, index 0 = M=4, index 1 = M=3
    int mm [2] = '{4, 3};
    int mp [2];
    int mfull [2];
    int mdata [2];
    int mchan [2];
    int acc [2];        // channel accepted in the last tick, -1 if none

    always #5 clk = ~clk;

    rr_mux #(.N(8), .M(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (d4),
        .in_valid  (v4),
        .in_ready  (rdy4),
        .out_data  (od4),
        .out_chan  (oc4),
        .out_valid (ov4),
        .out_ready (r4)
`ifdef RR_MUX_FORCE_EN
        ,
        .force_en  (fe4),
        .force_sel (fs4)
`endif
    );

    rr_mux #(.N(8), .M(3)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (d3),
        .in_valid  (v3),
        .in_ready  (rdy3),
        .out_data  (od3),
        .out_chan  (oc3),
        .out_valid (ov3),
        .out_ready (r3)
`ifdef RR_MUX_FORCE_EN
        ,
        .force_en  (fe3),
        .force_sel (fs3)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Set of channels that may be granted, as a bitmask
    function automatic int elig(input int k);
        int  v;
        bit  fe;
        int  fs;
        v  = (k == 0) ? int'(v4) : int'(v3);
        fe = (k == 0) ? fe4 : fe3;
        fs = (k == 0) ? int'(fs4) : int'(fs3);
`ifdef RR_MUX_FORCE_EN
        if (fe) return (fs < mm[k]) ? (v & (1 << fs)) : 0;
`endif
        return v;
    endfunction

    // First eligible channel after the pointer, going round modulo M
    function automatic int grant(input int k, input int el);
        for (int off = 1; off <= mm[k]; off++) begin
            int c;
            c = (mp[k] + off) % mm[k];
            if (el[c]) return c;
        end
        return -1;
    endfunction

    function automatic int word_of(input int k, input int ch);
        if (k == 0) return int'((d4 >> (8 * ch)) & 32'hFF);
        return int'((d3 >> (8 * ch)) & 24'hFF);
    endfunction

    // One clock cycle. Inputs are already set, just after a falling edge.
    // Check in_ready before the rising edge, advance the model at the edge,
    // then check the registered outputs on the next falling edge.
    task automatic tick();
        int          g [2];
        bit          ld [2];
        int          rr;
        int          exp_rdy;
        logic [31:0] o_rdy, o_v, o_d, o_c;
        #1;
        for (int k = 0; k < 2; k++) begin
            rr    = (k == 0) ? int'(r4) : int'(r3);
            g[k]  = grant(k, elig(k));
            ld[k] = (mfull[k] == 0) || (rr != 0);
            exp_rdy = (rst_n && ld[k] && g[k] >= 0) ? (1 << g[k]) : 0;
            o_rdy = (k == 0) ? 32'(rdy4) : 32'(rdy3);
            chk($sformatf("in_ready_m%0d", mm[k]), o_rdy, exp_rdy);
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            rr     = (k == 0) ? int'(r4) : int'(r3);
            acc[k] = -1;
            if (!rst_n) begin
                mp[k] = mm[k] - 1; mfull[k] = 0; mdata[k] = 0; mchan[k] = 0;
            end else if (ld[k] && g[k] >= 0) begin
                mfull[k] = 1; mdata[k] = word_of(k, g[k]); mchan[k] = g[k];
                mp[k] = g[k]; acc[k] = g[k];
            end else if (rr != 0) begin
                mfull[k] = 0;
            end
        end
        @(negedge clk);
        cyc++;
        for (int k = 0; k < 2; k++) begin
            o_v = (k == 0) ? 32'(ov4) : 32'(ov3);
            o_d = (k == 0) ? 32'(od4) : 32'(od3);
            o_c = (k == 0) ? 32'(oc4) : 32'(oc3);
            chk($sformatf("out_valid_m%0d", mm[k]), o_v, mfull[k]);
            chk($sformatf("out_data_m%0d", mm[k]),  o_d, mdata[k]);
            chk($sformatf("out_chan_m%0d", mm[k]),  o_c, mchan[k]);
        end
        $display("cyc %0d rst_n=%b | m4 v=%b rdy=%b ov=%b ch=%0d d=%h | m3 v=%b rdy=%b ov=%b ch=%0d d=%h",
                 cyc, rst_n, v4, rdy4, ov4, oc4, od4, v3, rdy3, ov3, oc3, od3);
    endtask

    // Random inputs that keep a valid word stable until it has been taken
    task automatic randomize_inputs();
        for (int c = 0; c < 4; c++) begin
            if (!(v4[c] && acc[0] != c)) begin
                v4[c] = 1'($urandom_range(0, 1));
                d4[8*c +: 8] = 8'($urandom);
            end
        end
        for (int c = 0; c < 3; c++) begin
            if (!(v3[c] && acc[1] != c)) begin
                v3[c] = 1'($urandom_range(0, 1));
                d3[8*c +: 8] = 8'($urandom);
            end
        end
        r4 = ($urandom_range(0, 3) != 0);
        r3 = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        int exp_alt [4] = '{3, 2, 3, 2};
        rst_n = 1'b0;
        v4 = '0; d4 = '0; r4 = 1'b0; fe4 = 1'b0; fs4 = '0;
        v3 = '0; d3 = '0; r3 = 1'b0; fe3 = 1'b0; fs3 = '0;
        for (int k = 0; k < 2; k++) begin
            mp[k] = mm[k] - 1; mfull[k] = 0; mdata[k] = 0; mchan[k] = 0; acc[k] = -1;
        end
        @(negedge clk);

        // Reset state
        tick();
        chk("rst_out_valid", 32'(ov4), 0);
        chk("rst_out_data",  32'(od4), 0);
        chk("rst_in_ready",  32'(rdy4), 0);
        rst_n = 1'b1;

        // All channels valid, data i+1: back-to-back rotation on both instances
        v4 = 4'hF; d4 = 32'h04030201; r4 = 1'b1;
        v3 = 3'h7; d3 = 24'h030201;   r3 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("rot_chan_m4", 32'(oc4), i % 4);
            chk("rot_data_m4", 32'(od4), (i % 4) + 1);
            chk("rot_valid_m4", 32'(ov4), 1);
            chk("rot_chan_m3", 32'(oc3), i % 3);
        end

        // Only channel 2 valid
        v4 = 4'b0100; d4 = 32'h00A50000;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("only2_data", 32'(od4), 32'hA5);
            chk("only2_rdy",  32'(rdy4), 32'b0100);
        end
        // Channels 2 and 3 alternate
        v4 = 4'b1100; d4 = 32'h33A50000;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("alt_chan", 32'(oc4), exp_alt[i]);
        end

        // Backpressure: load channel 1, then stall with all channels valid
        v4 = 4'b0010; d4 = 32'h00002200;
        tick();
        chk("bp_load_chan", 32'(oc4), 1);
        v4 = 4'hF; d4 = 32'h44332211; r4 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_data", 32'(od4), 32'h22);
            chk("bp_hold_chan", 32'(oc4), 1);
            chk("bp_hold_rdy",  32'(rdy4), 0);
        end
        r4 = 1'b1;
        tick();
        chk("bp_next_chan", 32'(oc4), 2);

        // Reset while full and stalled
        r4 = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        chk("mid_rst_valid", 32'(ov4), 0);
        chk("mid_rst_data",  32'(od4), 0);
        chk("mid_rst_rdy",   32'(rdy4), 0);
        rst_n = 1'b1; r4 = 1'b1;
        tick();
        chk("post_rst_chan", 32'(oc4), 0);
        chk("post_rst_data", 32'(od4), 32'h11);

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            tick();
        end

`ifdef RR_MUX_FORCE_EN
        // Forced selection
        v4 = 4'hF; r4 = 1'b1; fe4 = 1'b1; fs4 = 2'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("force_chan", 32'(oc4), 3);
        end
        // Out-of-range select on the M=3 instance grants nothing
        v3 = 3'h7; r3 = 1'b1; fe3 = 1'b1; fs3 = 2'd3;
        tick();
        tick();
        chk("force_oor_rdy",   32'(rdy3), 0);
        chk("force_oor_valid", 32'(ov3), 0);
        fe4 = 1'b0; fe3 = 1'b0;
        tick();
        chk("force_release_chan", 32'(oc4), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
